// File: rtl/loadstore_fsm.sv
// Multi-cycle MIPS load/store unit: one access per start, 2 cycles to done (3 for RMW stores).
// mem_waitrequest stalls the current access with all bus outputs held; busy stalls the pipeline.
module loadstore_fsm #(
  parameter int ADDR_W     = 32,
  parameter int RMW_STORES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        op,
  input  logic [31:0]       base,
  input  logic [15:0]       offset,
  input  logic [31:0]       rt_in,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              addr_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata
);
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_RMW_READ, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        op_q;
  logic [31:0]       rt_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] ea_q;
  logic [31:0]       ea_full;
  logic [1:0]        o;
  logic              in_load, in_store, in_misal, in_sub, q_sub;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_fmt, rmw_word, st_data;
  logic [3:0]        st_be;

  assign ea_full     = base + {{16{offset[15]}}, offset};
  assign o           = ea_q[1:0];
  assign mem_address = {ea_q[ADDR_W-1:2], 2'b00};
  assign in_sub      = (op == OP_SB) || (op == OP_SH);
  assign q_sub       = (op_q == OP_SB) || (op_q == OP_SH);

  always_comb begin
    in_load  = 1'b0;
    in_store = 1'b0;
    in_misal = 1'b0;
    case (op)
      OP_LB, OP_LBU, OP_LWL, OP_LWR: in_load = 1'b1;
      OP_LH, OP_LHU: begin in_load  = 1'b1; in_misal = ea_full[0];    end
      OP_LW:         begin in_load  = 1'b1; in_misal = |ea_full[1:0]; end
      OP_SB:         in_store = 1'b1;
      OP_SH:         begin in_store = 1'b1; in_misal = ea_full[0];    end
      OP_SW:         begin in_store = 1'b1; in_misal = |ea_full[1:0]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (in_misal)                         state_d = S_ERR;
        else if (in_load)                     state_d = S_READ;
        else if (!in_store)                   state_d = S_DONE;
        else if ((RMW_STORES != 0) && in_sub) state_d = S_RMW_READ;
        else                                  state_d = S_WRITE;
      end
      S_READ:     if (!mem_waitrequest) state_d = S_DONE;
      S_RMW_READ: if (!mem_waitrequest) state_d = S_WRITE;
      S_WRITE:    if (!mem_waitrequest) state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Lane k of the bus word is byte offset k (little-endian).
  always_comb begin
    rd_byte = mem_readdata[{o, 3'b000} +: 8];
    rd_half = o[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    ld_fmt  = mem_readdata;
    case (op_q)
      OP_LB:  ld_fmt = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU: ld_fmt = {24'h0, rd_byte};
      OP_LH:  ld_fmt = {{16{rd_half[15]}}, rd_half};
      OP_LHU: ld_fmt = {16'h0, rd_half};
      OP_LWL: case (o)
        2'd0:    ld_fmt = {mem_readdata[7:0],  rt_q[23:0]};
        2'd1:    ld_fmt = {mem_readdata[15:0], rt_q[15:0]};
        2'd2:    ld_fmt = {mem_readdata[23:0], rt_q[7:0]};
        default: ld_fmt = mem_readdata;
      endcase
      OP_LWR: case (o)
        2'd1:    ld_fmt = {rt_q[31:24], mem_readdata[31:8]};
        2'd2:    ld_fmt = {rt_q[31:16], mem_readdata[31:16]};
        2'd3:    ld_fmt = {rt_q[31:8],  mem_readdata[31:24]};
        default: ld_fmt = mem_readdata;
      endcase
      default: ;
    endcase
  end

  always_comb begin
    rmw_word = mem_readdata;
    if (op_q == OP_SH) begin
      if (o[1]) rmw_word[31:16] = rt_q[15:0];
      else      rmw_word[15:0]  = rt_q[15:0];
    end else begin
      rmw_word[{o, 3'b000} +: 8] = rt_q[7:0];
    end
    st_data = rt_q;
    st_be   = 4'b1111;
    if ((RMW_STORES != 0) && q_sub) begin
      st_data = wdata_q;
    end else if (op_q == OP_SB) begin
      st_data = {4{rt_q[7:0]}};
      st_be   = 4'b0001 << o;
    end else if (op_q == OP_SH) begin
      st_data = {2{rt_q[15:0]}};
      st_be   = o[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rt_q      <= '0;
      ea_q      <= '0;
      wdata_q   <= '0;
      load_data <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        op_q <= op;
        rt_q <= rt_in;
        ea_q <= ea_full[ADDR_W-1:0];
      end
      if (state_q == S_READ && !mem_waitrequest)     load_data <= ld_fmt;
      if (state_q == S_RMW_READ && !mem_waitrequest) wdata_q   <= rmw_word;
    end
  end

  // Moore outputs: every bus output is a function of registered state only,
  // so it stays stable for as long as waitrequest holds the state.
  always_comb begin
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE) || (state_q == S_ERR);
    addr_error     = (state_q == S_ERR);
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = 4'b0000;
    mem_writedata  = 32'h0;
    case (state_q)
      S_READ, S_RMW_READ: begin
        mem_read       = 1'b1;
        mem_byteenable = 4'b1111;
      end
      S_WRITE: begin
        mem_write      = 1'b1;
        mem_byteenable = st_be;
        mem_writedata  = st_data;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_loadstore_fsm.sv
// Scoreboard bench: dut0 uses byte-enable stores, dut1 read-modify-write stores.
module tb_loadstore_fsm;
  localparam logic [5:0] LB  = 6'b100000, LH  = 6'b100001, LWL = 6'b100010;
  localparam logic [5:0] LW  = 6'b100011, LBU = 6'b100100, LHU = 6'b100101;
  localparam logic [5:0] LWR = 6'b100110, SB  = 6'b101000, SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  typedef struct { int d; logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } bus_t;
  typedef struct { int d; logic err; logic [31:0] ld; int lat; } done_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_s [2];
  logic [5:0]  op;
  logic [31:0] base, rt_in, rdata;
  logic [15:0] offset;
  logic        wq;
  logic        bsy [2], dn [2], aerr [2], mr [2], mw [2];
  logic [31:0] ld [2], maddr [2], mwd [2];
  logic [3:0]  mbe [2];

  bus_t  bus_q [$];
  done_t done_q [$];
  int    cyc = 0, t_start = 0, n_chk = 0, n_pass = 0;
  logic        p_hold [2], p_mr [2], p_mw [2];
  logic [31:0] p_addr [2], p_wd [2];
  logic [3:0]  p_be [2];

  loadstore_fsm #(.ADDR_W(32), .RMW_STORES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op(op), .base(base), .offset(offset),
    .rt_in(rt_in), .busy(bsy[0]), .done(dn[0]), .load_data(ld[0]), .addr_error(aerr[0]),
    .mem_address(maddr[0]), .mem_read(mr[0]), .mem_write(mw[0]), .mem_byteenable(mbe[0]),
    .mem_writedata(mwd[0]), .mem_waitrequest(wq), .mem_readdata(rdata));

  loadstore_fsm #(.ADDR_W(32), .RMW_STORES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op(op), .base(base), .offset(offset),
    .rt_in(rt_in), .busy(bsy[1]), .done(dn[1]), .load_data(ld[1]), .addr_error(aerr[1]),
    .mem_address(maddr[1]), .mem_read(mr[1]), .mem_write(mw[1]), .mem_byteenable(mbe[1]),
    .mem_writedata(mwd[1]), .mem_waitrequest(wq), .mem_readdata(rdata));

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic bad(input string nm);
    n_chk++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic exp_rd(input int d, input logic [31:0] a);
    bus_t e;
    e.d = d; e.wr = 1'b0; e.addr = a; e.be = 4'b1111; e.wd = 32'h0;
    bus_q.push_back(e);
  endtask

  task automatic exp_wr(input int d, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus_t e;
    e.d = d; e.wr = 1'b1; e.addr = a; e.be = be; e.wd = wd;
    bus_q.push_back(e);
  endtask

  task automatic exp_dn(input int d, input logic err, input logic [31:0] l, input int lat);
    done_t e;
    e.d = d; e.err = err; e.ld = l; e.lat = lat;
    done_q.push_back(e);
  endtask

  // Called one step after a rising edge; start is seen on the next edge.
  task automatic issue(input int d);
    start_s[d] = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int k = 0;
    while (bsy[d] && k < 40) begin @(posedge clk); #1; k++; end
    if (bsy[d]) bad("timeout_busy");
  endtask

  task automatic run(input int d, input logic [5:0] o, input logic [31:0] b,
                     input logic [15:0] off, input logic [31:0] rt, input logic [31:0] rd);
    op = o; base = b; offset = off; rt_in = rt; rdata = rd;
    issue(d);
    wait_idle(d);
  endtask

  // Monitor: pops expectations whenever a DUT completes a bus access or signals done.
  initial begin
    bus_t  eb;
    done_t ed;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          p_hold[d] = 1'b0;
        end else begin
          if (mr[d] && mw[d]) bad("both_strobes");
          if (p_hold[d]) begin
            chk("hold_strobe", {30'd0, mr[d], mw[d]}, {30'd0, p_mr[d], p_mw[d]});
            chk("hold_addr", maddr[d], p_addr[d]);
            chk("hold_be", {28'd0, mbe[d]}, {28'd0, p_be[d]});
            chk("hold_wdata", mwd[d], p_wd[d]);
          end
          if ((mr[d] || mw[d]) && !wq) begin
            if (bus_q.size() == 0) bad("unexpected_access");
            else begin
              eb = bus_q.pop_front();
              chk("bus_dut", 32'(d), 32'(eb.d));
              chk("bus_write", {31'd0, mw[d]}, {31'd0, eb.wr});
              chk("bus_addr", maddr[d], eb.addr);
              chk("bus_be", {28'd0, mbe[d]}, {28'd0, eb.be});
              if (eb.wr) chk("bus_wdata", mwd[d], eb.wd);
            end
          end
          if (dn[d]) begin
            if (done_q.size() == 0) bad("unexpected_done");
            else begin
              ed = done_q.pop_front();
              chk("done_dut", 32'(d), 32'(ed.d));
              chk("addr_error", {31'd0, aerr[d]}, {31'd0, ed.err});
              chk("load_data", ld[d], ed.ld);
              chk("latency", 32'(cyc - t_start), 32'(ed.lat));
            end
          end
          p_hold[d] = (mr[d] || mw[d]) && wq;
          p_mr[d] = mr[d]; p_mw[d] = mw[d];
          p_addr[d] = maddr[d]; p_be[d] = mbe[d]; p_wd[d] = mwd[d];
        end
      end
    end
  end

  initial begin
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    p_hold[0] = 1'b0; p_hold[1] = 1'b0;
    op = 6'd0; base = 32'h0; offset = 16'h0; rt_in = 32'h0; rdata = 32'h0; wq = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", {31'd0, bsy[d]}, 32'd0);
      chk("rst_done", {31'd0, dn[d] | aerr[d]}, 32'd0);
      chk("rst_strobes", {30'd0, mr[d], mw[d]}, 32'd0);
      chk("rst_be", {28'd0, mbe[d]}, 32'd0);
      chk("rst_wdata", mwd[d], 32'd0);
      chk("rst_addr", maddr[d], 32'd0);
      chk("rst_load_data", ld[d], 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Plain word load
    exp_rd(0, 32'h104); exp_dn(0, 1'b0, 32'hDEADBEEF, 2);
    run(0, LW, 32'h100, 16'h0004, 32'h0, 32'hDEADBEEF);

    // Sub-word loads, including a negative offset (0x110 - 0xD = 0x103)
    exp_rd(0, 32'h100); exp_dn(0, 1'b0, 32'hFFFFFF80, 2);
    run(0, LB, 32'h110, 16'hFFF3, 32'h0, 32'h80112233);
    exp_rd(0, 32'h100); exp_dn(0, 1'b0, 32'h00000080, 2);
    run(0, LBU, 32'h100, 16'h0003, 32'h0, 32'h80112233);
    exp_rd(0, 32'h100); exp_dn(0, 1'b0, 32'hFFFF8011, 2);
    run(0, LH, 32'h100, 16'h0002, 32'h0, 32'h80112233);
    exp_rd(0, 32'h100); exp_dn(0, 1'b0, 32'h00008011, 2);
    run(0, LHU, 32'h100, 16'h0002, 32'h0, 32'h80112233);

    // Unaligned word merges
    exp_rd(0, 32'h100); exp_dn(0, 1'b0, 32'hCCDD3344, 2);
    run(0, LWL, 32'h100, 16'h0001, 32'h11223344, 32'hAABBCCDD);
    exp_rd(0, 32'h100); exp_dn(0, 1'b0, 32'h11AABBCC, 2);
    run(0, LWR, 32'h100, 16'h0001, 32'h11223344, 32'hAABBCCDD);
    exp_rd(0, 32'h100); exp_dn(0, 1'b0, 32'h112233AA, 2);
    run(0, LWR, 32'h100, 16'h0003, 32'h11223344, 32'hAABBCCDD);

    // Byte-enable stores; load_data keeps the last load result
    exp_wr(0, 32'h200, 4'b0100, 32'hA5A5A5A5); exp_dn(0, 1'b0, 32'h112233AA, 2);
    run(0, SB, 32'h200, 16'h0002, 32'h000000A5, 32'h0);
    exp_wr(0, 32'h200, 4'b1100, 32'hBEEFBEEF); exp_dn(0, 1'b0, 32'h112233AA, 2);
    run(0, SH, 32'h200, 16'h0002, 32'h1234BEEF, 32'h0);
    exp_wr(0, 32'h204, 4'b1111, 32'hCAFEF00D); exp_dn(0, 1'b0, 32'h112233AA, 2);
    run(0, SW, 32'h200, 16'h0004, 32'hCAFEF00D, 32'h0);

    // Read-modify-write stores
    exp_rd(1, 32'h200); exp_wr(1, 32'h200, 4'b1111, 32'h11A53344); exp_dn(1, 1'b0, 32'h0, 3);
    run(1, SB, 32'h200, 16'h0002, 32'h000000A5, 32'h11223344);
    exp_rd(1, 32'h200); exp_wr(1, 32'h200, 4'b1111, 32'h1122BEEF); exp_dn(1, 1'b0, 32'h0, 3);
    run(1, SH, 32'h200, 16'h0000, 32'h5555BEEF, 32'h11223344);
    exp_wr(1, 32'h208, 4'b1111, 32'h01020304); exp_dn(1, 1'b0, 32'h0, 2);
    run(1, SW, 32'h208, 16'h0000, 32'h01020304, 32'h0);

    // Three wait states, with a start pulse while busy that must be ignored
    wq = 1'b1; op = LW; base = 32'h300; offset = 16'h0; rdata = 32'h0BADF00D;
    exp_rd(0, 32'h300); exp_dn(0, 1'b0, 32'h0BADF00D, 5);
    issue(0);
    op = SW; start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 wq = 1'b0;
    wait_idle(0);

    // Misaligned accesses and an unknown opcode
    exp_dn(0, 1'b1, 32'h0BADF00D, 1);
    run(0, LW, 32'h100, 16'h0002, 32'h0, 32'h0);
    exp_dn(0, 1'b1, 32'h0BADF00D, 1);
    run(0, SH, 32'h200, 16'h0001, 32'h0, 32'h0);
    exp_dn(0, 1'b0, 32'h0BADF00D, 1);
    run(0, 6'b001000, 32'h100, 16'h0000, 32'h0, 32'h0);

    // Reset mid-write abandons the access
    wq = 1'b1; op = SW; base = 32'h400; offset = 16'h0; rt_in = 32'h12345678;
    issue(0);
    chk("pre_rst_write", {31'd0, mw[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_write", {31'd0, mw[0]}, 32'd0);
    chk("rst_mid_busy", {31'd0, bsy[0]}, 32'd0);
    chk("rst_mid_load_data", ld[0], 32'd0);
    chk("rst_mid_addr", maddr[0], 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; wq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
